// File: rtl/countup_gen.sv
// -----------------------------------------------------------------------------
// countup_gen
//
// Counting-pattern source for link and datapath bring-up. It emits a stream of
// DATA_WIDTH-bit words, each one equal to the previous word plus STEP
// (wrapping modulo 2^DATA_WIDTH), together with a valid strobe. It is set up
// and observed over RBCP.
//
// Ports:
//   clk         in   1           system clock, the only clock
//   rst         in   1           synchronous reset, active high
//   data        out  DATA_WIDTH  pattern word (registered)
//   data_valid  out  1           high on cycles that carry a pattern word
//   busy        out  1           high while the generator is running
//   rbcp_we     in   1           RBCP write strobe
//   rbcp_re     in   1           RBCP read strobe
//   rbcp_ack    out  1           RBCP acknowledge, one cycle after the request
//   rbcp_addr   in   32          RBCP address
//   rbcp_wd     in   8           RBCP write data
//   rbcp_rd     out  8           RBCP read data, valid only in the ack cycle
//
// Register map (rbcp_addr[7:0]):
//   0x00 CTRL   wr: bit0 RUN, bit1 SRST (counter <= SEED), bit2 INJ
//               rd: {5'b0, inj_pending, 1'b0, busy}
//   0x01/0x02   SEED low / high byte (high byte holds SEED[DW-1:8])
//   0x03        STEP, zero-extended to DW
//   0x04/0x05   BURST low / high byte (0 = continuous)
//   0x06/0x07   counter low / high byte, read only
//
// Build option:
//   COUNTUP_GEN_ERRINJ_EN - when defined, CTRL.INJ arms a single-word error
//   injection (bit0 of the next emitted word is inverted). When undefined,
//   INJ is ignored and the stream is never corrupted.
//
// DATA_WIDTH must satisfy 8 < DATA_WIDTH <= 16.
// -----------------------------------------------------------------------------
module countup_gen #(
  parameter int          DATA_WIDTH  = 14,
  parameter logic [31:0] RBCP_OFFSET = 32'h1500_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  output logic                  busy,
  input  logic                  rbcp_we,
  input  logic                  rbcp_re,
  output logic                  rbcp_ack,
  input  logic [31:0]           rbcp_addr,
  input  logic [7:0]            rbcp_wd,
  output logic [7:0]            rbcp_rd
);

  localparam int DW = DATA_WIDTH;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   counter_q, counter_d;
  logic [DW-1:0]   seed_q, seed_d;
  logic [7:0]      step_q, step_d;
  logic [15:0]     burst_q, burst_d;
  logic [15:0]     remaining_q, remaining_d;
  logic [DW-1:0]   data_q, data_d;
  logic            data_valid_q, data_valid_d;
  logic            ack_q, ack_d;
  logic [7:0]      rd_q, rd_d;

  logic            inj_pending;

  logic            sel;
  logic            wr_en;
  logic            rd_en;
  logic [7:0]      reg_addr;
  logic [15:0]     seed_ext;
  logic [15:0]     counter_ext;

  assign sel         = (rbcp_addr[31:8] == RBCP_OFFSET[31:8]);
  assign wr_en       = sel & rbcp_we;
  assign rd_en       = sel & rbcp_re;
  assign reg_addr    = rbcp_addr[7:0];
  assign seed_ext    = 16'(seed_q);
  assign counter_ext = 16'(counter_q);

`ifdef COUNTUP_GEN_ERRINJ_EN
  logic inj_pending_q, inj_pending_d;

  // Set wins over the per-word clear so an INJ written while running is
  // applied to the word after the write, not lost.
  always_comb begin
    inj_pending_d = inj_pending_q;
    if (state_q == S_RUN) begin
      inj_pending_d = 1'b0;
    end
    if (wr_en && (reg_addr == 8'h00) && rbcp_wd[2]) begin
      inj_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_pending_q <= 1'b0;
    end else begin
      inj_pending_q <= inj_pending_d;
    end
  end

  assign inj_pending = inj_pending_q;
`else
  assign inj_pending = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state, datapath and register-write logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    seed_d       = seed_q;
    step_d       = step_q;
    burst_d      = burst_q;
    remaining_d  = remaining_q;
    data_d       = data_q;
    data_valid_d = 1'b0;

    // Datapath: one word per cycle while running. remaining == 0 means
    // continuous; the word emitted with remaining == 1 is the last one.
    if (state_q == S_RUN) begin
      data_d       = counter_q ^ {{(DW-1){1'b0}}, inj_pending};
      data_valid_d = 1'b1;
      counter_d    = counter_q + {{(DW-8){1'b0}}, step_q};
      if (remaining_q != 16'd0) begin
        remaining_d = remaining_q - 16'd1;
        if (remaining_q == 16'd1) begin
          state_d = S_IDLE;
        end
      end
    end

    // Register writes take effect on the edge that samples rbcp_we. They are
    // evaluated after the datapath so SRST overrides the increment and a
    // RUN=0 write overrides the burst bookkeeping.
    if (wr_en) begin
      case (reg_addr)
        8'h00: begin
          if (rbcp_wd[0] && (state_q == S_IDLE)) begin
            state_d     = S_RUN;
            remaining_d = burst_q;
          end else if (!rbcp_wd[0] && (state_q == S_RUN)) begin
            state_d = S_IDLE;
          end
          if (rbcp_wd[1]) begin
            counter_d = seed_q;
          end
        end
        8'h01:   seed_d[7:0]    = rbcp_wd;
        8'h02:   seed_d[DW-1:8] = rbcp_wd[DW-9:0];
        8'h03:   step_d         = rbcp_wd;
        8'h04:   burst_d[7:0]   = rbcp_wd;
        8'h05:   burst_d[15:8]  = rbcp_wd;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RBCP acknowledge and read data: captured in the request cycle so they
  // appear, registered, exactly one cycle later. rd is forced to 0 outside
  // the ack cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    ack_d = sel & (rbcp_we | rbcp_re);
    rd_d  = 8'h00;
    if (rd_en) begin
      case (reg_addr)
        8'h00:   rd_d = {5'b0, inj_pending, 1'b0, (state_q == S_RUN)};
        8'h01:   rd_d = seed_ext[7:0];
        8'h02:   rd_d = seed_ext[15:8];
        8'h03:   rd_d = step_q;
        8'h04:   rd_d = burst_q[7:0];
        8'h05:   rd_d = burst_q[15:8];
        8'h06:   rd_d = counter_ext[7:0];
        8'h07:   rd_d = counter_ext[15:8];
        default: rd_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      counter_q    <= '0;
      seed_q       <= '0;
      step_q       <= 8'd1;
      burst_q      <= 16'd0;
      remaining_q  <= 16'd0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      ack_q        <= 1'b0;
      rd_q         <= 8'h00;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      seed_q       <= seed_d;
      step_q       <= step_d;
      burst_q      <= burst_d;
      remaining_q  <= remaining_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      ack_q        <= ack_d;
      rd_q         <= rd_d;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign busy       = (state_q == S_RUN);
  assign rbcp_ack   = ack_q;
  assign rbcp_rd    = rd_q;

endmodule

// File: tb/tb_countup_gen.sv
module tb_countup_gen;

  localparam int          DW   = 14;
  localparam logic [31:0] BASE = 32'h1500_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data;
  logic          data_valid;
  logic          busy;
  logic          rbcp_we;
  logic          rbcp_re;
  logic          rbcp_ack;
  logic [31:0]   rbcp_addr;
  logic [7:0]    rbcp_wd;
  logic [7:0]    rbcp_rd;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];

  countup_gen #(
    .DATA_WIDTH (DW),
    .RBCP_OFFSET(BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .data_valid(data_valid),
    .busy      (busy),
    .rbcp_we   (rbcp_we),
    .rbcp_re   (rbcp_re),
    .rbcp_ack  (rbcp_ack),
    .rbcp_addr (rbcp_addr),
    .rbcp_wd   (rbcp_wd),
    .rbcp_rd   (rbcp_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: every valid word must match the oldest expected word.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_word: observed 0x%0h expected none", data);
      end
      if (exp_q.size() != 0) begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (data === e) else begin
          errors++;
          $error("FAIL stream_word: observed 0x%0h expected 0x%0h", data, e);
        end
        $display("word 0x%0h (expected 0x%0h)", data, e);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic rbcp_write(input logic [31:0] addr, input logic [7:0] wd, input logic exp_ack);
    rbcp_addr = addr;
    rbcp_wd   = wd;
    rbcp_we   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rbcp_we = 1'b0;
    chk("wr_ack", {31'b0, rbcp_ack}, {31'b0, exp_ack});
    $display("write addr 0x%08h data 0x%02h ack %0b", addr, wd, rbcp_ack);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] wd);
    rbcp_write(BASE | {24'b0, a}, wd, 1'b1);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] expv);
    rbcp_addr = BASE | {24'b0, a};
    rbcp_re   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rbcp_re = 1'b0;
    chk("rd_ack", {31'b0, rbcp_ack}, 32'd1);
    chk("rd_data", {24'b0, rbcp_rd}, {24'b0, expv});
    $display("read addr 0x%02h data 0x%02h (expected 0x%02h)", a, rbcp_rd, expv);
    @(negedge clk);
    chk("ack_idle", {31'b0, rbcp_ack}, 32'd0);
    chk("rd_idle", {24'b0, rbcp_rd}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    rbcp_we   = 1'b0;
    rbcp_re   = 1'b0;
    rbcp_addr = 32'h0;
    rbcp_wd   = 8'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_data", {18'b0, data}, 32'd0);
    chk("rst_valid", {31'b0, data_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ack", {31'b0, rbcp_ack}, 32'd0);
    chk("rst_rd", {24'b0, rbcp_rd}, 32'd0);
    rd(8'h03, 8'h01);
    rd(8'h00, 8'h00);
    rd(8'h06, 8'h00);

    // Address decode: other block ignored and not acked; unmapped reads zero
    rbcp_write(32'h1600_0003, 8'h55, 1'b0);
    rd(8'h03, 8'h01);
    wr(8'h10, 8'hAA);
    rd(8'h10, 8'h00);

    // Wrap-around stream from SEED=0x3FFE, high-byte mask on SEED
    wr(8'h01, 8'hFE);
    wr(8'h02, 8'hFF);
    rd(8'h02, 8'h3F);
    rd(8'h06, 8'h00);
    wr(8'h03, 8'h01);
    exp_q.push_back(14'h3FFE);
    exp_q.push_back(14'h3FFF);
    exp_q.push_back(14'h0000);
    exp_q.push_back(14'h0001);
    wr(8'h00, 8'h03);
    chk("first_latency_valid", {31'b0, data_valid}, 32'd0);
    chk("run_busy", {31'b0, busy}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("run_busy", {31'b0, busy}, 32'd1);
    end
    wr(8'h00, 8'h00);
    @(negedge clk);
    chk("wrap_stop_valid", {31'b0, data_valid}, 32'd0);
    chk("wrap_queue_empty", exp_q.size(), 32'd0);

    // Error injection: armed in idle, consumed by the first word of the run
    wr(8'h01, 8'h20);
    wr(8'h02, 8'h00);
    wr(8'h00, 8'h02);
    rd(8'h06, 8'h20);
    wr(8'h00, 8'h04);
`ifdef COUNTUP_GEN_ERRINJ_EN
    rd(8'h00, 8'h04);
    exp_q.push_back(14'h0021);
`else
    rd(8'h00, 8'h00);
    exp_q.push_back(14'h0020);
`endif
    exp_q.push_back(14'h0021);
    exp_q.push_back(14'h0022);
    exp_q.push_back(14'h0023);
    wr(8'h00, 8'h05);
    repeat (3) @(negedge clk);
    wr(8'h00, 8'h00);
    @(negedge clk);
    chk("inj_stop_valid", {31'b0, data_valid}, 32'd0);
    chk("inj_queue_empty", exp_q.size(), 32'd0);
    rd(8'h00, 8'h00);

    // SRST while running: jump to SEED without a gap, then stop timing
    wr(8'h01, 8'h00);
    wr(8'h02, 8'h01);
    exp_q.push_back(14'h0024);
    exp_q.push_back(14'h0025);
    exp_q.push_back(14'h0100);
    exp_q.push_back(14'h0101);
    wr(8'h00, 8'h01);
    @(negedge clk);
    wr(8'h00, 8'h03);
    chk("srst_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    wr(8'h00, 8'h00);
    chk("stop_busy", {31'b0, busy}, 32'd0);
    chk("stop_valid_first", {31'b0, data_valid}, 32'd1);
    @(negedge clk);
    chk("stop_valid_second", {31'b0, data_valid}, 32'd0);
    chk("srst_queue_empty", exp_q.size(), 32'd0);

    // Burst of 3 words with STEP=4
    wr(8'h01, 8'h10);
    wr(8'h02, 8'h00);
    wr(8'h03, 8'h04);
    wr(8'h04, 8'h03);
    wr(8'h05, 8'h00);
    exp_q.push_back(14'h0010);
    exp_q.push_back(14'h0014);
    exp_q.push_back(14'h0018);
    wr(8'h00, 8'h03);
    repeat (3) @(negedge clk);
    chk("burst_last_valid", {31'b0, data_valid}, 32'd1);
    chk("burst_end_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("burst_after_valid", {31'b0, data_valid}, 32'd0);
    repeat (3) @(negedge clk);
    chk("burst_idle_valid", {31'b0, data_valid}, 32'd0);
    chk("burst_queue_empty", exp_q.size(), 32'd0);
    rd(8'h06, 8'h1C);
    rd(8'h07, 8'h00);

    // Reset in the middle of a burst
    wr(8'h01, 8'h40);
    wr(8'h02, 8'h00);
    wr(8'h03, 8'h01);
    wr(8'h04, 8'h0A);
    exp_q.push_back(14'h0040);
    exp_q.push_back(14'h0041);
    wr(8'h00, 8'h03);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", {31'b0, data_valid}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_data", {18'b0, data}, 32'd0);
    chk("midrst_queue_empty", exp_q.size(), 32'd0);
    rd(8'h01, 8'h00);
    rd(8'h02, 8'h00);
    rd(8'h03, 8'h01);
    rd(8'h04, 8'h00);
    rd(8'h06, 8'h00);
    repeat (3) @(negedge clk);
    chk("final_valid", {31'b0, data_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
